// File: rtl/dm_sba_csr_ctrl.sv
// RISC-V debug module system bus access: SBCS/SBAddress/SBData CSRs and bus master FSM.
// Define DM_SBA_AUTOINC_EN to enable sbautoincrement support.
module dm_sba_csr_ctrl #(
    parameter int unsigned BUS_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    dmi_req_valid_i,
    input  logic [6:0]              dmi_req_addr_i,
    input  logic [1:0]              dmi_req_op_i,
    input  logic [31:0]             dmi_req_data_i,
    output logic                    dmi_resp_valid_o,
    output logic [31:0]             dmi_resp_data_o,
    output logic [1:0]              dmi_resp_resp_o,
    output logic                    sbreq_o,
    output logic                    sbwe_o,
    output logic [ADDR_WIDTH-1:0]   sbaddr_o,
    output logic [BUS_WIDTH-1:0]    sbwdata_o,
    output logic [BUS_WIDTH/8-1:0]  sbbe_o,
    input  logic                    sbgnt_i,
    input  logic                    sbrvalid_i,
    input  logic [BUS_WIDTH-1:0]    sbrdata_i,
    input  logic                    sberr_i
);
    localparam int unsigned OFFW  = (BUS_WIDTH == 64) ? 3 : 2;
    localparam int unsigned BEW   = BUS_WIDTH / 8;
    localparam logic        SUP64 = (BUS_WIDTH == 64);

    localparam logic [6:0] A_SBCS  = 7'h38;
    localparam logic [6:0] A_SBA0  = 7'h39;
    localparam logic [6:0] A_SBA1  = 7'h3A;
    localparam logic [6:0] A_SBD0  = 7'h3C;
    localparam logic [6:0] A_SBD1  = 7'h3D;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_e;
    state_e state_q, state_d;

    logic                  busyerr_q, busyerr_d;
    logic                  readonaddr_q, readonaddr_d;
    logic [2:0]            access_q, access_d;
    logic                  autoinc_q, autoinc_d;
    logic                  readondata_q, readondata_d;
    logic [2:0]            sberror_q, sberror_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [BUS_WIDTH-1:0]  data_q, data_d;
    logic                  we_q, we_d;
    logic [2:0]            acc_q, acc_d;
    logic                  resp_valid_q;
    logic [31:0]           resp_data_q, resp_data_d;
    logic [1:0]            resp_q, resp_d;

    logic                  busy, is_rd, is_wr, sb_reg, trigger, trig_we;
    logic                  size_bad, misal;
    logic [63:0]           addr_ext, data_ext;
    logic [31:0]           sbcs_rd;
    logic [BUS_WIDTH-1:0]  rd_shift, rd_val, wdata;
    logic [BEW-1:0]        be_base, be;

    assign busy = (state_q != S_IDLE);

    assign sbcs_rd = {3'd1, 6'd0, busyerr_q, busy, readonaddr_q, access_q, autoinc_q,
                      readondata_q, sberror_q, 7'(ADDR_WIDTH), 1'b0, SUP64, 1'b1, 2'b00};

    // Lane steering uses the size latched at issue so SBCS writes mid-access cannot disturb it.
    always_comb begin
        rd_shift = sbrdata_i >> {addr_q[OFFW-1:0], 3'b000};
        rd_val   = '0;
        if (acc_q == 3'd3) begin
            rd_val = rd_shift;
        end else begin
            rd_val[31:0] = rd_shift[31:0];
        end
        wdata   = (acc_q == 3'd3) ? data_q : {(BUS_WIDTH/32){data_q[31:0]}};
        be_base = (acc_q == 3'd3) ? '1 : BEW'(4'hF);
        be      = be_base << addr_q[OFFW-1:0];
    end

    always_comb begin
        state_d      = state_q;
        busyerr_d    = busyerr_q;
        readonaddr_d = readonaddr_q;
        access_d     = access_q;
        autoinc_d    = autoinc_q;
        readondata_d = readondata_q;
        sberror_d    = sberror_q;
        we_d         = we_q;
        acc_d        = acc_q;
        resp_data_d  = '0;
        resp_d       = 2'd0;
        trigger      = 1'b0;
        trig_we      = 1'b0;
        addr_ext     = '0;
        addr_ext[ADDR_WIDTH-1:0] = addr_q;
        data_ext     = '0;
        data_ext[BUS_WIDTH-1:0]  = data_q;

        is_rd  = dmi_req_valid_i && (dmi_req_op_i == 2'd1);
        is_wr  = dmi_req_valid_i && (dmi_req_op_i == 2'd2);
        sb_reg = (dmi_req_addr_i == A_SBA0) || (dmi_req_addr_i == A_SBA1) ||
                 (dmi_req_addr_i == A_SBD0) || (dmi_req_addr_i == A_SBD1);

        if ((is_rd || is_wr) && sb_reg && busy) begin
            busyerr_d = 1'b1;
            resp_d    = 2'd3;
        end else if (is_rd) begin
            case (dmi_req_addr_i)
                A_SBCS: resp_data_d = sbcs_rd;
                A_SBA0: resp_data_d = addr_ext[31:0];
                A_SBA1: resp_data_d = addr_ext[63:32];
                A_SBD0: begin
                    resp_data_d = data_ext[31:0];
                    trigger     = readondata_q;
                end
                A_SBD1: resp_data_d = data_ext[63:32];
                default: ;
            endcase
        end else if (is_wr) begin
            case (dmi_req_addr_i)
                A_SBCS: begin
                    busyerr_d    = busyerr_q & ~dmi_req_data_i[22];
                    readonaddr_d = dmi_req_data_i[20];
                    access_d     = dmi_req_data_i[19:17];
`ifdef DM_SBA_AUTOINC_EN
                    autoinc_d    = dmi_req_data_i[16];
`else
                    autoinc_d    = 1'b0;
`endif
                    readondata_d = dmi_req_data_i[15];
                    sberror_d    = sberror_q & ~dmi_req_data_i[14:12];
                end
                A_SBA0: begin
                    addr_ext[31:0] = dmi_req_data_i;
                    trigger        = readonaddr_q;
                end
                A_SBA1: addr_ext[63:32] = dmi_req_data_i;
                A_SBD0: begin
                    data_ext[31:0] = dmi_req_data_i;
                    trigger        = 1'b1;
                    trig_we        = 1'b1;
                end
                A_SBD1: data_ext[63:32] = dmi_req_data_i;
                default: ;
            endcase
        end

        // Upper halves fall off here when the corresponding width is 32.
        addr_d = addr_ext[ADDR_WIDTH-1:0];
        data_d = data_ext[BUS_WIDTH-1:0];

        size_bad = (access_q < 3'd2) || (access_q > 3'(OFFW));
        misal    = (access_q == 3'd3) ? (|addr_d[2:0]) : (|addr_d[1:0]);

        if (trigger && !busyerr_q && (sberror_q == 3'd0)) begin
            if (size_bad) begin
                sberror_d = 3'd4;
            end else if (misal) begin
                sberror_d = 3'd3;
            end else begin
                state_d = S_REQ;
                we_d    = trig_we;
                acc_d   = access_q;
            end
        end

        case (state_q)
            S_REQ: begin
                if (sbgnt_i) state_d = S_RESP;
            end
            S_RESP: begin
                if (sbrvalid_i) begin
                    state_d = S_IDLE;
                    if (sberr_i) begin
                        sberror_d = 3'd2;
                    end else begin
                        if (!we_q) data_d = rd_val;
`ifdef DM_SBA_AUTOINC_EN
                        if (autoinc_q) begin
                            addr_d = addr_q + ((acc_q == 3'd3) ? ADDR_WIDTH'(8) : ADDR_WIDTH'(4));
                        end
`endif
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            busyerr_q    <= 1'b0;
            readonaddr_q <= 1'b0;
            access_q     <= '0;
            autoinc_q    <= 1'b0;
            readondata_q <= 1'b0;
            sberror_q    <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            we_q         <= 1'b0;
            acc_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_q       <= '0;
        end else begin
            state_q      <= state_d;
            busyerr_q    <= busyerr_d;
            readonaddr_q <= readonaddr_d;
            access_q     <= access_d;
            autoinc_q    <= autoinc_d;
            readondata_q <= readondata_d;
            sberror_q    <= sberror_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            we_q         <= we_d;
            acc_q        <= acc_d;
            resp_valid_q <= dmi_req_valid_i;
            resp_data_q  <= resp_data_d;
            resp_q       <= resp_d;
        end
    end

    assign dmi_resp_valid_o = resp_valid_q;
    assign dmi_resp_data_o  = resp_data_q;
    assign dmi_resp_resp_o  = resp_q;

    assign sbreq_o   = (state_q == S_REQ);
    assign sbwe_o    = sbreq_o & we_q;
    assign sbaddr_o  = sbreq_o ? addr_q : '0;
    assign sbwdata_o = sbreq_o ? wdata : '0;
    assign sbbe_o    = sbreq_o ? be : '0;

endmodule
